// File: rtl/key_pkg.sv
// Shared types and sizing helpers for the multi-key debounce controller.
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } chan_state_e;

  // Clock cycles per 1 ms tick.
  function automatic int ms_div(input int clk_freq);
    return clk_freq / 1000;
  endfunction

  // Width able to hold 0..limit; never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/key_multi_ctrl_if.sv
// Button inputs and per-channel event outputs of the multi-key controller.
interface key_multi_ctrl_if #(
  parameter int N_KEYS = 4
);

  logic [N_KEYS-1:0] key_i;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic [N_KEYS-1:0] toggle_o;

  modport master (
    output key_i,
    input  key_level, key_press, key_release, key_long, toggle_o
  );

  modport slave (
    input  key_i,
    output key_level, key_press, key_release, key_long, toggle_o
  );

endinterface

// File: rtl/key_chan.sv
// One key channel: 2-FF synchroniser, ms-tick debounce, press/hold FSM and toggle.
module key_chan
  import key_pkg::*;
#(
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 0,
  parameter bit TOGGLE_INIT    = 1'b1
) (
  input  logic clk_100m,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_key_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_toggle
);

  localparam int HOLD_LIM = LONG_MS - DEBOUNCE_MS;
  localparam int REP_LIM  = (REPEAT_MS > 0) ? REPEAT_MS : 1;
  localparam int DB_W     = cnt_w(DEBOUNCE_MS);
  localparam int HOLD_W   = cnt_w(HOLD_LIM);
  localparam int REP_W    = cnt_w(REP_LIM);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_LIM - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_LIM - 1);
  localparam logic              IDLE_RAW  = KEY_ACTIVE_LOW;

  logic [1:0]        r_sync;
  logic              r_level;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [REP_W-1:0]  r_rep_cnt;
  chan_state_e       r_state;
  logic              r_press;
  logic              r_release;
  logic              r_long;
  logic              r_toggle;

  logic w_s;
  logic w_accept;
  logic w_rise;
  logic w_fall;

  // Debounced level change is accepted on the tick that completes the disagreement window.
  always_comb begin
    w_s      = r_sync[1] ^ IDLE_RAW;
    w_accept = 1'b0;
    if ((w_s != r_level) && i_tick && (r_db_cnt == DB_LAST)) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
    w_rise = w_accept & ~r_level;
    w_fall = w_accept & r_level;
  end

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      r_sync     <= {2{IDLE_RAW}};
      r_level    <= 1'b0;
      r_db_cnt   <= '0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_state    <= ST_IDLE;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
      r_toggle   <= TOGGLE_INIT;
    end else begin
      r_sync    <= {r_sync[0], i_key_raw};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;

      if (w_s == r_level) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_db_cnt <= '0;
        r_level  <= ~r_level;
      end else if (i_tick && (r_db_cnt != DB_LAST)) begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end

      // A release always wins over a long/repeat tick landing in the same cycle.
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state    <= ST_PRESSED;
            r_press    <= 1'b1;
            r_toggle   <= ~r_toggle;
            r_hold_cnt <= '0;
          end
        end
        ST_PRESSED: begin
          if (w_fall) begin
            r_state   <= ST_IDLE;
            r_release <= 1'b1;
          end else if (i_tick) begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_state   <= ST_HELD;
              r_long    <= 1'b1;
              r_rep_cnt <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
        end
        ST_HELD: begin
          if (w_fall) begin
            r_state   <= ST_IDLE;
            r_release <= 1'b1;
          end else if (i_tick && (REPEAT_MS > 0)) begin
            if (r_rep_cnt == REP_LAST) begin
              r_long    <= 1'b1;
              r_rep_cnt <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + REP_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_toggle  = r_toggle;

endmodule

// File: rtl/key_multi_ctrl.sv
// N-channel push-button controller: one shared 1 ms prescaler feeding per-key channels.
module key_multi_ctrl
  import key_pkg::*;
#(
  parameter int              CLK_FREQ       = 100000000,
  parameter int              N_KEYS         = 4,
  parameter bit              KEY_ACTIVE_LOW = 1'b1,
  parameter int              DEBOUNCE_MS    = 20,
  parameter int              LONG_MS        = 1000,
  parameter int              REPEAT_MS      = 0,
  parameter logic [N_KEYS-1:0] TOGGLE_INIT  = {N_KEYS{1'b1}}
) (
  input logic             clk_100m,
  input logic             rst_n,
  key_multi_ctrl_if.slave bus
);

  localparam int DIV   = ms_div(CLK_FREQ);
  localparam int PRE_W = cnt_w(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0]  r_pre;
  logic              w_tick;
  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;
  logic [N_KEYS-1:0] w_long;
  logic [N_KEYS-1:0] w_toggle;

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_chan #(
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
      .DEBOUNCE_MS    (DEBOUNCE_MS),
      .LONG_MS        (LONG_MS),
      .REPEAT_MS      (REPEAT_MS),
      .TOGGLE_INIT    (TOGGLE_INIT[g])
    ) u_chan (
      .clk_100m  (clk_100m),
      .rst_n     (rst_n),
      .i_tick    (w_tick),
      .i_key_raw (bus.key_i[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g]),
      .o_long    (w_long[g]),
      .o_toggle  (w_toggle[g])
    );
  end

  assign bus.key_level   = w_level;
  assign bus.key_press   = w_press;
  assign bus.key_release = w_release;
  assign bus.key_long    = w_long;
  assign bus.toggle_o    = w_toggle;

endmodule

// File: tb/tb_key_multi_ctrl.sv
// Scoreboard bench for key_multi_ctrl: ms-level reference model predicts pulses, monitor compares.
module tb_key_multi_ctrl;

  localparam int CLK_FREQ = 10000;
  localparam int N        = 2;
  localparam int DB       = 3;
  localparam int LONG     = 10;
  localparam int REP      = 2;
  localparam int DIV      = CLK_FREQ / 1000;
  localparam logic [1:0] TINIT = 2'b11;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } exp_t;

  logic clk_100m = 1'b0;
  logic rst_n;

  key_multi_ctrl_if #(.N_KEYS(N)) bus ();

  key_multi_ctrl #(
    .CLK_FREQ       (CLK_FREQ),
    .N_KEYS         (N),
    .KEY_ACTIVE_LOW (1'b1),
    .DEBOUNCE_MS    (DB),
    .LONG_MS        (LONG),
    .REPEAT_MS      (REP),
    .TOGGLE_INIT    (TINIT)
  ) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_100m = ~clk_100m;

  exp_t       sb_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  bit         model_ok = 1'b0;
  logic [1:0] m_level;
  logic [1:0] m_toggle;
  int         cnt_press[N];
  int         cnt_rel[N];
  int         cnt_long[N];
  int         cnt_both = 0;

  // Reference model: works in ms ticks, "ms of disagreement" and "ms since accepted press".
  initial begin : p_model
    int         pre;
    logic [1:0] h1, h2, s, pr, rl, lg;
    int         dis[N];
    int         held_ms[N];
    bit         held[N];
    bit         tick, acc;
    pre = 0; h1 = 2'b11; h2 = 2'b11;
    forever begin
      @(posedge clk_100m);
      cyc++;
      pr = '0; rl = '0; lg = '0;
      if (!rst_n) begin
        pre = 0; h1 = 2'b11; h2 = 2'b11;
        m_level = 2'b00; m_toggle = TINIT;
        for (int ch = 0; ch < N; ch++) begin
          dis[ch] = 0; held[ch] = 1'b0; held_ms[ch] = 0;
        end
      end else begin
        tick = (pre == DIV - 1);
        pre  = tick ? 0 : pre + 1;
        s    = ~h2;
        for (int ch = 0; ch < N; ch++) begin
          acc = 1'b0;
          if (s[ch] == m_level[ch]) dis[ch] = 0;
          else if (tick) begin
            dis[ch]++;
            if (dis[ch] == DB) begin
              acc = 1'b1; dis[ch] = 0; m_level[ch] = s[ch];
            end
          end
          if (acc && m_level[ch]) begin
            pr[ch] = 1'b1; m_toggle[ch] = ~m_toggle[ch]; held[ch] = 1'b1; held_ms[ch] = 0;
          end else if (acc) begin
            rl[ch] = 1'b1; held[ch] = 1'b0;
          end else if (held[ch] && tick) begin
            held_ms[ch]++;
            if (held_ms[ch] == LONG - DB) lg[ch] = 1'b1;
            else if (REP > 0 && held_ms[ch] > LONG - DB && ((held_ms[ch] - (LONG - DB)) % REP) == 0)
              lg[ch] = 1'b1;
          end
        end
        h2 = h1; h1 = bus.key_i;
      end
      model_ok = 1'b1;
      if ((pr | rl | lg) != 2'b00) sb_q.push_back('{cyc, pr, rl, lg});
    end
  end

  // Monitor: compares level/toggle every cycle and pops the scoreboard on any pulse.
  initial begin : p_mon
    logic [1:0] ep, er, el;
    for (int ch = 0; ch < N; ch++) begin
      cnt_press[ch] = 0; cnt_rel[ch] = 0; cnt_long[ch] = 0;
    end
    forever begin
      @(negedge clk_100m);
      if (model_ok) begin
        vectors++;
        if (bus.key_level !== m_level || bus.toggle_o !== m_toggle) begin
          miscompares++;
          $display("FAIL state cyc=%0d: level=%b toggle=%b, required level=%b toggle=%b",
                   cyc, bus.key_level, bus.toggle_o, m_level, m_toggle);
        end
        ep = '0; er = '0; el = '0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
          ep = sb_q[0].press; er = sb_q[0].rel; el = sb_q[0].lng;
          void'(sb_q.pop_front());
        end
        if ((ep | er | el | bus.key_press | bus.key_release | bus.key_long) != 2'b00) begin
          vectors++;
          if (bus.key_press !== ep || bus.key_release !== er || bus.key_long !== el) begin
            miscompares++;
            $display("FAIL pulses cyc=%0d: press=%b rel=%b long=%b, required press=%b rel=%b long=%b",
                     cyc, bus.key_press, bus.key_release, bus.key_long, ep, er, el);
          end
        end
        for (int ch = 0; ch < N; ch++) begin
          cnt_press[ch] += int'(bus.key_press[ch]);
          cnt_rel[ch]   += int'(bus.key_release[ch]);
          cnt_long[ch]  += int'(bus.key_long[ch]);
        end
        if (bus.key_press === 2'b11) cnt_both++;
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_100m);
  endtask

  initial begin : p_stim
    int p0, r0, l0, p1, r1, l1, b0;
    rst_n = 1'b0;
    bus.key_i = 2'b11;
    step(5);
    check("reset level", int'(bus.key_level), 0);
    check("reset toggle", int'(bus.toggle_o), 3);
    check("reset pulses", int'(bus.key_press | bus.key_release | bus.key_long), 0);
    rst_n = 1'b1;
    step(100);
    check("idle presses", cnt_press[0] + cnt_press[1], 0);

    // Clean short press on channel 0.
    p0 = cnt_press[0]; r0 = cnt_rel[0]; l0 = cnt_long[0];
    bus.key_i[0] = 1'b0; step(60);
    bus.key_i[0] = 1'b1; step(60);
    check("short press", cnt_press[0] - p0, 1);
    check("short release", cnt_rel[0] - r0, 1);
    check("short long", cnt_long[0] - l0, 0);
    check("short toggle", int'(bus.toggle_o[0]), 0);

    // Bounce, then a stable press.
    p0 = cnt_press[0];
    for (int i = 0; i < 14; i++) begin
      bus.key_i[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(15);
    end
    check("bounce no press", cnt_press[0] - p0, 0);
    bus.key_i[0] = 1'b0; step(60);
    check("bounce one press", cnt_press[0] - p0, 1);
    bus.key_i[0] = 1'b1; step(60);

    // Long press with repeat on channel 1.
    p0 = cnt_press[0]; p1 = cnt_press[1]; r1 = cnt_rel[1]; l1 = cnt_long[1];
    bus.key_i[1] = 1'b0; step(200);
    bus.key_i[1] = 1'b1; step(60);
    check("long press", cnt_press[1] - p1, 1);
    check("long release", cnt_rel[1] - r1, 1);
    check("long pulses>=5", int'((cnt_long[1] - l1) >= 5), 1);
    check("ch0 untouched", cnt_press[0] - p0, 0);

    // Simultaneous press, then reset while both are held.
    b0 = cnt_both;
    bus.key_i = 2'b00; step(85);
    check("simultaneous press", cnt_both - b0, 1);
    check("toggle before reset", int'(bus.toggle_o), 2);
    rst_n = 1'b0; step(5);
    check("mid reset level", int'(bus.key_level), 0);
    check("mid reset toggle", int'(bus.toggle_o), 3);
    rst_n = 1'b1;
    b0 = cnt_both;
    step(40);
    check("press after reset", cnt_both - b0, 1);
    bus.key_i = 2'b11; step(60);

    // Randomised segments with occasional reset pulses.
    for (int i = 0; i < 40; i++) begin
      bus.key_i = 2'($urandom_range(0, 3));
      step($urandom_range(3, 70));
      if ($urandom_range(0, 11) == 0) begin
        rst_n = 1'b0; step(2); rst_n = 1'b1;
      end
    end
    bus.key_i = 2'b11; step(80);
    check("scoreboard drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
